dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Data-memory responder on the far side of the core's dram interface.
- Serves the core's always-active read address with registered read data, applies byte-enabled writes, and zero-fills the array after reset.
- Flags illegal writes as a sticky fault.
- Sits beside the core at top level; its read data feeds the core's dram read-data input.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_LOG2, 10, log2 of word count; capacity = 2^DEPTH_LOG2 words of XLEN bits.
- BASE_ADDR, 32'h0001_0000, byte base address; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- dram_rd_addr_i  input  XLEN  byte read address, sampled every cycle.
- dram_rd_data_o  output  XLEN  registered read data for the address sampled at the previous edge.
- dram_wr_addr_i  input  XLEN  byte write address.
- dram_wr_data_i  input  XLEN  write data; lane k = bits [8k+7:8k].
- dram_wr_byte_en_i  input  4  lane enables; 4'b0000 = no write.
- ready_o  output  1  high once zero-fill is complete.
- fault_o  output  1  sticky illegal-write flag.
- fault_addr_o  output  XLEN  write address of the first faulting access.

Behaviour:
- Reset (async, rst_n_i low):
  - dram_rd_data_o=0, ready_o=0, fault_o=0, fault_addr_o=0.
  - FSM enters INIT; clear counter = 0.
  - Array contents are not reset directly; the INIT walk clears them.
- Address decode:
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2.
  - Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored for indexing.
- FSM INIT:
  - Each cycle writes 0 to word[counter], then counter++.
  - After the cycle that writes word 2^DEPTH_LOG2-1, go to RUN.
  - ready_o rises on the same edge, so INIT lasts exactly 2^DEPTH_LOG2 cycles.
  - During INIT:
    - Core writes are ignored and do not fault.
    - dram_rd_data_o is driven 0.
- FSM RUN: stays in RUN until reset. A reset asserted mid-INIT or mid-RUN returns to INIT and restarts the clear from word 0.
- Read (RUN): one-cycle latency.
  - At each edge, dram_rd_data_o <= word[index(dram_rd_addr_i)].
  - Out-of-range read returns 0 and does not fault.
- Write (RUN, byte_en != 0): lanes with byte_en[k]=1 are updated at the edge; other lanes are kept.
- Legal byte_en patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Write fault: an out-of-range address OR an illegal pattern (e.g. 0110, 0101, 0111):
  - The write is suppressed entirely.
  - fault_o <= 1.
  - fault_addr_o <= dram_wr_addr_i, only if fault_o was 0 (first fault is retained).
  - fault_o clears only on reset.
- Simultaneous read and write to the same word (write-first forwarding): dram_rd_data_o at the next edge = old word with the enabled lanes replaced by dram_wr_data_i. Suppressed (faulting) writes are not forwarded.
- No backpressure: one read and one write are accepted every RUN cycle.
- ready_o must be consumed by the top level to hold the core in reset.

Test Plan:
- Reset release with DEPTH_LOG2=4:
  - ready_o low for exactly 16 cycles, then high.
  - A pre-seeded 32'hDEAD_BEEF at word 3 reads 0 after ready.
- Write 32'h1234_5678, be=1111, to 32'h0001_0008; next cycle read 32'h0001_0008 -> dram_rd_data_o = 32'h1234_5678 one cycle after the address is presented.
- Lane write: be=0010, data 32'h0000_AB00, to the same word -> read returns 32'h1234_AB78.
- Same-cycle write be=1100, data 32'hCAFE_0000, and read of the same word -> next-cycle dram_rd_data_o = 32'hCAFE_AB78.
- Illegal pattern and out-of-range write:
  - Write be=0110 at 32'h0001_000C -> memory unchanged, fault_o=1, fault_addr_o=32'h0001_000C.
  - A later write to 32'h0002_0000 leaves fault_addr_o unchanged.
  - Reading 32'h0002_0000 returns 0.
- Reset asserted at INIT cycle 7 and released:
  - Outputs zero immediately.
  - INIT restarts and takes the full 16 cycles.
  - fault_o=0.

Source files
------------

// File: rtl/dram_responder.sv
// dram_responder: data-memory responder with registered reads, byte-enabled writes,
// zero-fill after reset and a sticky illegal-write fault.
module dram_responder #(
  parameter int XLEN = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  output logic [XLEN-1:0] dram_rd_data_o,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  output logic            ready_o,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_addr_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic fault_q, fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic rd_in, wr_in, be_legal, wr_req, wr_ok, wr_fault;
  logic [XLEN-1:0] wr_merged;
  logic unused_lsb;
  // BASE_ADDR is aligned to the array size, so range check reduces to the upper bits
  assign rd_in = dram_rd_addr_i[XLEN-1:DEPTH_LOG2+2] == BASE_ADDR[XLEN-1:DEPTH_LOG2+2];
  assign wr_in = dram_wr_addr_i[XLEN-1:DEPTH_LOG2+2] == BASE_ADDR[XLEN-1:DEPTH_LOG2+2];
  assign rd_idx = dram_rd_addr_i[DEPTH_LOG2+1:2];
  assign wr_idx = dram_wr_addr_i[DEPTH_LOG2+1:2];
  assign unused_lsb = ^{dram_rd_addr_i[1:0], dram_wr_addr_i[1:0]};
  assign be_legal = dram_wr_byte_en_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                              4'b0011, 4'b1100, 4'b1111};
  assign wr_req = state_q == RUN && dram_wr_byte_en_i != 4'b0000;
  assign wr_ok = wr_req && wr_in && be_legal;
  assign wr_fault = wr_req && !wr_ok;
  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int k = 0; k < 4; k++)
      if (dram_wr_byte_en_i[k]) wr_merged[8*k +: 8] = dram_wr_data_i[8*k +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? RUN : INIT;
    end
    // write-first: a same-word legal write is forwarded to the read port
    rd_data_d = (state_q == RUN && rd_in)
              ? ((wr_ok && wr_idx == rd_idx) ? wr_merged : mem_q[rd_idx]) : '0;
    fault_d = fault_q | wr_fault;
    fault_addr_d = (wr_fault && !fault_q) ? dram_wr_addr_i : fault_addr_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= INIT;
      cnt_q <= '0;
      rd_data_q <= '0;
      fault_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      fault_q <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) mem_q[cnt_q] <= '0;
    else if (wr_ok) mem_q[wr_idx] <= wr_merged;
  end
  assign dram_rd_data_o = rd_data_q;
  assign ready_o = state_q == RUN;
  assign fault_o = fault_q;
  assign fault_addr_o = fault_addr_q;
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: randomized and directed checks of dram_responder against an array model.
module tb_dram_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int WORDS = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] rd_addr = BASE, wr_addr = BASE, wr_data = '0;
  logic [3:0] be = 4'b0000;
  logic [31:0] rd_data, fault_addr;
  logic ready, fault;
  int compared = 0, mismatched = 0;
  logic [31:0] mem_m [WORDS];
  logic [31:0] exp_rd, faddr_m;
  bit fault_m;
  int init_left;

  dram_responder #(.XLEN(32), .DEPTH_LOG2(4), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dram_rd_addr_i(rd_addr), .dram_rd_data_o(rd_data),
    .dram_wr_addr_i(wr_addr), .dram_wr_data_i(wr_data), .dram_wr_byte_en_i(be),
    .ready_o(ready), .fault_o(fault), .fault_addr_o(fault_addr));

  always #5 clk = ~clk;

  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'd4 * WORDS;
  endfunction

  function automatic bit legal(input logic [3:0] b);
    return b == 4'h1 || b == 4'h2 || b == 4'h4 || b == 4'h8 ||
           b == 4'h3 || b == 4'hC || b == 4'hF;
  endfunction

  task automatic model_reset();
    rst_n = 1'b0;
    init_left = WORDS;
    for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
    fault_m = 1'b0;
    faddr_m = '0;
    exp_rd = '0;
  endtask

  task automatic tick();
    int w;
    if (init_left > 0) begin
      init_left--;
      exp_rd = '0;
    end else begin
      if (be != 4'b0000) begin
        if (in_rng(wr_addr) && legal(be)) begin
          w = int'((wr_addr - BASE) / 4);
          for (int k = 0; k < 4; k++)
            if (be[k]) mem_m[w][8*k +: 8] = wr_data[8*k +: 8];
        end else begin
          if (!fault_m) faddr_m = wr_addr;
          fault_m = 1'b1;
        end
      end
      exp_rd = in_rng(rd_addr) ? mem_m[int'((rd_addr - BASE) / 4)] : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
      compared++;
      if (rd_data !== 32'h0) begin
        mismatched++;
        $display("FAIL %s_init_rd: got %h want 0", tag, rd_data);
      end
    end
    compared++;
    if (n !== WORDS) begin
      mismatched++;
      $display("FAIL %s_init_len: got %0d cycles want %0d", tag, n, WORDS);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    compared++;
    if ({rd_data, ready, fault, fault_addr} !== '0) begin
      mismatched++;
      $display("FAIL reset_out: got rd=%h rdy=%b f=%b fa=%h want all 0", rd_data, ready, fault, fault_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("reset");
  endtask

  task automatic test_directed();
    wr_addr = 32'h0001_0008; wr_data = 32'h1234_5678; be = 4'b1111; rd_addr = BASE;
    tick();
    be = 4'b0000; rd_addr = 32'h0001_0008;
    tick();
    compared++;
    if (rd_data !== 32'h1234_5678) begin
      mismatched++;
      $display("FAIL full_write: got %h want 12345678", rd_data);
    end
    wr_data = 32'h0000_AB00; be = 4'b0010; rd_addr = BASE;
    tick();
    be = 4'b0000; rd_addr = 32'h0001_0008;
    tick();
    compared++;
    if (rd_data !== 32'h1234_AB78) begin
      mismatched++;
      $display("FAIL lane_write: got %h want 1234ab78", rd_data);
    end
    wr_data = 32'hCAFE_0000; be = 4'b1100;
    tick();
    compared++;
    if (rd_data !== 32'hCAFE_AB78) begin
      mismatched++;
      $display("FAIL fwd_write: got %h want cafeab78", rd_data);
    end
    wr_addr = 32'h0001_000C; wr_data = 32'hFFFF_FFFF; be = 4'b0110; rd_addr = 32'h0001_000C;
    tick();
    compared++;
    if ({fault, fault_addr, rd_data} !== {1'b1, 32'h0001_000C, 32'h0}) begin
      mismatched++;
      $display("FAIL illegal_be: got f=%b fa=%h rd=%h want 1 0001000c 0", fault, fault_addr, rd_data);
    end
    wr_addr = 32'h0002_0000; be = 4'b1111; rd_addr = 32'h0002_0000;
    tick();
    compared++;
    if ({fault, fault_addr, rd_data} !== {1'b1, 32'h0001_000C, 32'h0}) begin
      mismatched++;
      $display("FAIL oor_write: got f=%b fa=%h rd=%h want 1 0001000c 0", fault, fault_addr, rd_data);
    end
    be = 4'b0000; rd_addr = 32'h0001_000C;
    tick();
    compared++;
    if (rd_data !== 32'h0) begin
      mismatched++;
      $display("FAIL fault_suppress: got %h want 0", rd_data);
    end
    rd_addr = 32'h0001_0008;
    tick();
    compared++;
    if (rd_data !== 32'hCAFE_AB78) begin
      mismatched++;
      $display("FAIL word_kept: got %h want cafeab78", rd_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] wa;
    model_reset();
    #2;
    rst_n = 1'b1;
    wait_ready("rand");
    for (int c = 0; c < 400; c++) begin
      case ($urandom % 8)
        0: wa = BASE + 32'd64 + ($urandom % 1024);
        1: wa = BASE - 32'd4 + ($urandom % 4);
        default: wa = BASE + 32'($urandom % 64);
      endcase
      wr_addr = wa;
      wr_data = $urandom;
      be = 4'($urandom % 16);
      rd_addr = ($urandom % 3 == 0) ? wa : BASE + 32'($urandom % 72);
      tick();
      compared++;
      if (rd_data !== exp_rd) begin
        mismatched++;
        $display("FAIL rand_rd cyc %0d: got %h want %h", c, rd_data, exp_rd);
      end
      compared++;
      if ({fault, fault_addr} !== {fault_m, faddr_m}) begin
        mismatched++;
        $display("FAIL rand_fault cyc %0d: got %b/%h want %b/%h", c, fault, fault_addr, fault_m, faddr_m);
      end
    end
    be = 4'b0000;
  endtask

  task automatic test_reset_mid_init();
    wr_addr = 32'h0001_000C; wr_data = 32'hDEAD_BEEF; be = 4'b1111; rd_addr = 32'h0001_000C;
    tick();
    compared++;
    if (rd_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL seed: got %h want deadbeef", rd_data);
    end
    be = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    #2;
    model_reset();
    #1;
    compared++;
    if ({rd_data, ready, fault, fault_addr} !== '0) begin
      mismatched++;
      $display("FAIL midinit_out: got rd=%h rdy=%b f=%b fa=%h want all 0", rd_data, ready, fault, fault_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("midinit");
    rd_addr = 32'h0001_000C;
    tick();
    compared++;
    if ({rd_data, fault} !== {32'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL cleared_word: got rd=%h f=%b want 0 0", rd_data, fault);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
